serial_bit_collector: RTL

//  Receive side of the bit-order path: collects a 1-bit serial stream into WIDTH-bit words.

---
 rtl/serial_bit_collector.sv | 70 +++++++
 1 files changed

// File: rtl/serial_bit_collector.sv
// serial_bit_collector: assembles a serial bit stream into WIDTH-bit words behind a valid/ready output register
module serial_bit_collector #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_valid,
  input  logic             ser_data,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_overrun
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg, word;
  logic             last, complete, hs, load, drop;
  assign last       = cnt == CW'(WIDTH - 1);
  assign complete   = ser_valid & ~frame_start & last;
  assign word       = LSB_FIRST ? {ser_data, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], ser_data};
  assign dout_valid = state == FULL;
  assign hs         = dout_valid & dout_ready;
  // output register next state: a completion only lands if the slot is empty or being drained
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    if (state == EMPTY) begin
      load      = complete;
      state_nxt = complete ? FULL : EMPTY;
    end else begin
      load      = complete & hs;
      drop      = complete & ~hs;
      state_nxt = (hs & ~complete) ? EMPTY : FULL;
    end
  end
  // shifter and bit counter; frame_start restarts the word, even over a would-be completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (ser_valid & frame_start) begin
      cnt   <= CW'(1);
      shreg <= LSB_FIRST ? {ser_data, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, ser_data};
    end else if (frame_start) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (ser_valid) begin
      cnt   <= last ? '0 : cnt + CW'(1);
      shreg <= word;
    end
  end
  // output word, handshake state and sticky overrun (a drop beats a simultaneous clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      dout    <= load ? word : dout;
      overrun <= drop | (overrun & ~clr_overrun);
    end
  end
endmodule
